// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and width helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // A zero MAX_HOLD still needs a one-bit counter so the datapath stays legal.
  function automatic int hold_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting sub-blocks and the arbiter.
interface rr_grant_arbiter_if #(
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
);
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin winner search starting just after the last owner.
module rr_pick #(
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            any,
  output logic [IDXW-1:0] win_idx,
  output logic [N-1:0]    win_onehot
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             start_s;
  int             off_s;
  int             win_s;

  // Rotate so index last+1 sits at bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    start_s = (int'(last) + 1) % N;
    dbl_s   = {req, req};
    rot_s   = N'(dbl_s >> start_s);
    off_s   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? j : off_s;
    end
    win_s = (start_s + off_s) % N;
    any   = |req;
    if (any) begin
      win_idx    = IDXW'(win_s);
      win_onehot = {{(N-1){1'b0}}, 1'b1} << win_s;
    end else begin
      win_idx    = {IDXW{1'b0}};
      win_onehot = {N{1'b0}};
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold limit and timeout pulse.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 255,
  parameter int HOLDW    = hold_width(MAX_HOLD)
) (
  input logic               clk,
  input logic               rst,
  rr_grant_arbiter_if.slave bus
);

  arb_state_t      state_r, state_nxt_s;
  logic [N-1:0]    gnt_r, gnt_nxt_s;
  logic [IDXW-1:0] idx_r, idx_nxt_s;
  logic [IDXW-1:0] last_r, last_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            timeout_r, timeout_nxt_s;
  logic [HOLDW-1:0] hold_r, hold_nxt_s;

  logic            any_s;
  logic [IDXW-1:0] win_idx_s;
  logic [N-1:0]    win_onehot_s;
  logic            owner_req_s;
  logic            expire_s;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req        (bus.req),
    .last       (last_r),
    .any        (any_s),
    .win_idx    (win_idx_s),
    .win_onehot (win_onehot_s)
  );

  assign owner_req_s = bus.req[idx_r];
  assign expire_s    = (MAX_HOLD != 0) && (hold_r == HOLDW'(MAX_HOLD));

  // Next-state and next-output decode; every release passes through IDLE for a bubble.
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    idx_nxt_s     = idx_r;
    valid_nxt_s   = valid_r;
    last_nxt_s    = last_r;
    hold_nxt_s    = hold_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s = GRANT;
          gnt_nxt_s   = win_onehot_s;
          idx_nxt_s   = win_idx_s;
          valid_nxt_s = 1'b1;
          last_nxt_s  = win_idx_s;
          hold_nxt_s  = HOLDW'(1);
        end else begin
          gnt_nxt_s   = {N{1'b0}};
          idx_nxt_s   = {IDXW{1'b0}};
          valid_nxt_s = 1'b0;
          hold_nxt_s  = {HOLDW{1'b0}};
        end
      end
      GRANT: begin
        if (bus.done || !owner_req_s || expire_s) begin
          state_nxt_s   = IDLE;
          gnt_nxt_s     = {N{1'b0}};
          idx_nxt_s     = {IDXW{1'b0}};
          valid_nxt_s   = 1'b0;
          hold_nxt_s    = {HOLDW{1'b0}};
          // A coinciding done or request drop makes the release a normal one.
          timeout_nxt_s = expire_s && !bus.done && owner_req_s;
        end else begin
          hold_nxt_s = (hold_r == {HOLDW{1'b1}}) ? hold_r : hold_r + HOLDW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {N{1'b0}};
        idx_nxt_s   = {IDXW{1'b0}};
        valid_nxt_s = 1'b0;
        hold_nxt_s  = {HOLDW{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant outputs, rotation pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r     <= {N{1'b0}};
      idx_r     <= {IDXW{1'b0}};
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      last_r    <= IDXW'(N - 1);
      hold_r    <= {HOLDW{1'b0}};
    end else begin
      gnt_r     <= gnt_nxt_s;
      idx_r     <= idx_nxt_s;
      valid_r   <= valid_nxt_s;
      timeout_r <= timeout_nxt_s;
      last_r    <= last_nxt_s;
      hold_r    <= hold_nxt_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = idx_r;
  assign bus.gnt_valid = valid_r;
  assign bus.timeout   = timeout_r;

endmodule
